// File: rtl/l1_cache_pkg.sv
// Shared types and geometry for the direct-mapped L1 cache.
// Tag and index widths are derived from the set count.
package l1_cache_pkg;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned WORDS    = LINE_W / WORD_W;
  localparam int unsigned LINE_B   = LINE_W / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_e;

  function automatic int unsigned index_w(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned num_sets);
    return ADDR_W - OFFSET_W - $clog2(num_sets);
  endfunction
endpackage

// File: rtl/cache_array.sv
// Tag and line storage: combinational read, per-byte line write, separate tag write.
// No reset; validity lives in the controller so it can be cleared asynchronously.
module cache_array
  import l1_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned TAG_W    = 24
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  index,
  input  logic [LINE_B-1:0] byte_we,
  input  logic [LINE_W-1:0] wline,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wtag,
  output logic [LINE_W-1:0] rline,
  output logic [TAG_W-1:0]  rtag
);
  logic [LINE_W-1:0] line_q [NUM_SETS];
  logic [TAG_W-1:0]  tag_q  [NUM_SETS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(LINE_B); b++) begin
      if (byte_we[b]) line_q[index][b*8 +: 8] <= wline[b*8 +: 8];
    end
    if (tag_we) tag_q[index] <= wtag;
  end

  assign rline = line_q[index];
  assign rtag  = tag_q[index];
endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back L1 cache with a 32-byte line and single outstanding miss.
// Hits respond in the same cycle; misses write back a dirty victim, then fetch.
module l1_cache
  import l1_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmem_read,
  input  logic              cmem_write,
  input  logic [3:0]        cmem_byte_enable,
  input  logic [31:0]       cmem_address,
  input  logic [31:0]       cmem_wdata,
  output logic              cmem_resp,
  output logic [31:0]       cmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  localparam int unsigned IDX_W = index_w(NUM_SETS);
  localparam int unsigned TAG_W = tag_w(NUM_SETS);

  state_e               state_q, state_d;
  logic [NUM_SETS-1:0]  valid_q, valid_d;
  logic [NUM_SETS-1:0]  dirty_q, dirty_d;

  logic [IDX_W-1:0]     index;
  logic [TAG_W-1:0]     req_tag;
  logic [2:0]           word_sel;
  logic                 req, hit;
  logic [LINE_B-1:0]    arr_byte_we;
  logic [LINE_W-1:0]    arr_wline;
  logic                 arr_tag_we;
  logic [LINE_W-1:0]    rline;
  logic [TAG_W-1:0]     rtag;
  logic                 addr_unused;

  assign index       = cmem_address[OFFSET_W +: IDX_W];
  assign req_tag     = cmem_address[ADDR_W-1 -: TAG_W];
  assign word_sel    = cmem_address[4:2];
  assign req         = cmem_read | cmem_write;
  assign hit         = valid_q[index] && (rtag == req_tag);
  assign addr_unused = ^cmem_address[1:0];

  cache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk     (clk),
    .index   (index),
    .byte_we (arr_byte_we),
    .wline   (arr_wline),
    .tag_we  (arr_tag_we),
    .wtag    (req_tag),
    .rline   (rline),
    .rtag    (rtag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Next state, array writes and the CPU/memory handshakes; write wins over read.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    arr_byte_we  = '0;
    arr_wline    = '0;
    arr_tag_we   = 1'b0;
    cmem_resp    = 1'b0;
    cmem_rdata   = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            cmem_resp = 1'b1;
            if (cmem_write) begin
              arr_byte_we    = LINE_B'(cmem_byte_enable) << {word_sel, 2'b00};
              arr_wline      = {WORDS{cmem_wdata}};
              dirty_d[index] = 1'b1;
            end else begin
              cmem_rdata = rline[{word_sel, 5'd0} +: WORD_W];
            end
          end else if (valid_q[index] && dirty_q[index]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {rtag, index, OFFSET_W'(0)};
        pmem_wdata   = rline;
        if (pmem_resp) state_d = FETCH;
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, index, OFFSET_W'(0)};
        if (pmem_resp) begin
          arr_byte_we    = '1;
          arr_wline      = pmem_rdata;
          arr_tag_we     = 1'b1;
          valid_d[index] = 1'b1;
          dirty_d[index] = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_l1_cache.sv
// Randomized self-checking bench for l1_cache against a line-level memory/cache model.
module tb_l1_cache;
  logic         clk;
  logic         rst_n;
  logic         cmem_read, cmem_write;
  logic [3:0]   cmem_byte_enable;
  logic [31:0]  cmem_address, cmem_wdata;
  logic         cmem_resp;
  logic [31:0]  cmem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  // Reference model: backing memory keyed by line address, plus per-set cache contents.
  logic [255:0] mem [logic [31:0]];
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [31:0]  m_laddr [8];
  logic [255:0] m_line  [8];
  logic [31:0]  last_rdata;
  logic [31:0]  last_wb_word0;

  l1_cache #(.NUM_SETS(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmem_read        (cmem_read),
    .cmem_write       (cmem_write),
    .cmem_byte_enable (cmem_byte_enable),
    .cmem_address     (cmem_address),
    .cmem_wdata       (cmem_wdata),
    .cmem_resp        (cmem_resp),
    .cmem_rdata       (cmem_rdata),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] get_line(input logic [31:0] la);
    logic [255:0] l;
    if (!mem.exists(la)) begin
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      mem[la] = l;
    end
    return mem[la];
  endfunction

  // One CPU access with a memory responder of 'lat' cycles; checks timing, traffic and data.
  task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be, input int lat);
    int idx, w, cyc, pcnt, nwb, nfe, exp_lat;
    bit hit, exp_wb, done;
    logic [31:0] la, vaddr;
    logic [255:0] victim, exp_line;
    idx      = int'(addr[7:5]);
    w        = int'(addr[4:2]);
    la       = {addr[31:5], 5'b0};
    hit      = m_valid[idx] && (m_laddr[idx] == la);
    exp_wb   = !hit && m_valid[idx] && m_dirty[idx];
    victim   = m_line[idx];
    vaddr    = m_laddr[idx];
    exp_line = hit ? m_line[idx] : get_line(la);
    exp_lat  = hit ? 0 : (exp_wb ? 1 + 2 * lat : 1 + lat);
    @(negedge clk);
    cmem_read = rd; cmem_write = wr; cmem_address = addr;
    cmem_wdata = wd; cmem_byte_enable = be;
    done = 0; cyc = 0; pcnt = 0; nwb = 0; nfe = 0;
    while (!done) begin
      #1;
      checks++;
      if (pmem_read && pmem_write) begin
        errors++; $display("FAIL pmem_exclusive: both pmem_read and pmem_write high at %h", addr);
      end
      if (cmem_resp) begin
        done = 1;
        checks++;
        if (cyc != exp_lat) begin
          errors++; $display("FAIL resp_latency addr %h: got %0d cycles, expected %0d", addr, cyc, exp_lat);
        end
        checks++;
        if (nwb != (exp_wb ? 1 : 0)) begin
          errors++; $display("FAIL writeback_count addr %h: got %0d expected %0d", addr, nwb, exp_wb ? 1 : 0);
        end
        checks++;
        if (nfe != (hit ? 0 : 1)) begin
          errors++; $display("FAIL fetch_count addr %h: got %0d expected %0d", addr, nfe, hit ? 0 : 1);
        end
        if (!wr) begin
          last_rdata = cmem_rdata;
          checks++;
          if (cmem_rdata !== exp_line[w*32 +: 32]) begin
            errors++; $display("FAIL read_data addr %h: got %h expected %h", addr, cmem_rdata, exp_line[w*32 +: 32]);
          end
        end
      end else begin
        checks++;
        if (cmem_rdata !== 32'h0) begin
          errors++; $display("FAIL rdata_idle addr %h: got %h expected 0", addr, cmem_rdata);
        end
        if (pmem_write) begin
          if (pcnt == 0) begin
            last_wb_word0 = pmem_wdata[31:0];
            checks++;
            if (!exp_wb || pmem_address !== vaddr) begin
              errors++; $display("FAIL wb_address: got %h expected %h (wb expected %0d)", pmem_address, vaddr, exp_wb);
            end
            checks++;
            if (pmem_wdata !== victim) begin
              errors++; $display("FAIL wb_data: got %h expected %h", pmem_wdata, victim);
            end
          end
          pcnt++;
          if (pcnt >= lat) begin pmem_resp = 1'b1; pcnt = 0; nwb++; end
        end else if (pmem_read) begin
          if (pcnt == 0) begin
            checks++;
            if (hit || pmem_address !== la) begin
              errors++; $display("FAIL fetch_address: got %h expected %h (hit %0d)", pmem_address, la, hit);
            end
          end
          pmem_rdata = exp_line;
          pcnt++;
          if (pcnt >= lat) begin pmem_resp = 1'b1; pcnt = 0; nfe++; end
        end
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      cyc++;
      if (!done && cyc > 200) begin
        checks++; errors++; done = 1;
        $display("FAIL timeout addr %h: no cmem_resp after %0d cycles, expected 1", addr, cyc);
      end
    end
    cmem_read = 1'b0; cmem_write = 1'b0;
    if (!hit) begin
      if (exp_wb) mem[vaddr] = victim;
      m_line[idx] = exp_line; m_laddr[idx] = la;
      m_valid[idx] = 1; m_dirty[idx] = 0;
    end
    if (wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_line[idx][w*32 + b*8 +: 8] = wd[b*8 +: 8];
      m_dirty[idx] = 1;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmem_read = 1'b1; cmem_address = 32'h40;
    #1;
    checks++;
    if (cmem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got resp=%b rd=%b wr=%b expected 0 0 0", cmem_resp, pmem_read, pmem_write);
    end
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (pmem_read !== 1'b0 || cmem_resp !== 1'b0) begin
        errors++; $display("FAIL reset_hold: got pmem_read=%b resp=%b expected 0 0", pmem_read, cmem_resp);
      end
    end
    @(negedge clk);
    cmem_read = 1'b0;
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_directed();
    logic [255:0] l;
    l = get_line(32'h40);
    l[31:0] = 32'hDEADBEEF;
    mem[32'h40] = l;
    do_access(0, 1, 32'h0000_0040, 32'h0, 4'h0, 3);
    checks++;
    if (last_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL cold_read: got %h expected deadbeef", last_rdata);
    end
    do_access(0, 1, 32'h0000_0044, 32'h0, 4'h0, 1);
    do_access(1, 0, 32'h0000_0040, 32'h11223344, 4'b0011, 1);
    do_access(0, 1, 32'h0000_0040, 32'h0, 4'h0, 1);
    checks++;
    if (last_rdata !== 32'hDEAD3344) begin
      errors++; $display("FAIL partial_write: got %h expected dead3344", last_rdata);
    end
    do_access(0, 1, 32'h0000_0140, 32'h0, 4'h0, 2);
    checks++;
    if (last_wb_word0 !== 32'hDEAD3344) begin
      errors++; $display("FAIL evict_wb_word0: got %h expected dead3344", last_wb_word0);
    end
  endtask

  task automatic test_read_write_both();
    do_access(1, 1, 32'h0000_0148, 32'hCAFEF00D, 4'b1111, 1);
    #1;
    checks++;
    if (cmem_resp !== 1'b0) begin
      errors++; $display("FAIL single_resp: got %b expected 0", cmem_resp);
    end
    do_access(0, 1, 32'h0000_0040, 32'h0, 4'h0, 2);
    do_access(0, 1, 32'h0000_0148, 32'h0, 4'h0, 1);
    checks++;
    if (last_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL both_is_write: got %h expected cafef00d", last_rdata);
    end
  endtask

  task automatic test_spurious_resp();
    @(negedge clk);
    pmem_rdata = '1;
    pmem_resp  = 1'b1;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      errors++; $display("FAIL spurious_idle: got rd=%b wr=%b expected 0 0", pmem_read, pmem_write);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    do_access(0, 1, 32'h0000_0148, 32'h0, 4'h0, 1);
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    cmem_read = 1'b1; cmem_address = 32'h0000_0240;
    @(negedge clk); #1;
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++; $display("FAIL fetch_started: got pmem_read=%b expected 1", pmem_read);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || cmem_resp !== 1'b0) begin
      errors++; $display("FAIL async_reset: got pmem_read=%b resp=%b expected 0 0", pmem_read, cmem_resp);
    end
    @(negedge clk);
    cmem_read = 1'b0;
    rst_n = 1'b1;
    clear_model();
    do_access(0, 1, 32'h0000_0240, 32'h0, 4'h0, 2);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    bit wr;
    for (int n = 0; n < 150; n++) begin
      addr = {22'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 2'($urandom)};
      wr   = 1'($urandom);
      do_access(wr, wr ? 1'($urandom) : 1'b1, addr, $urandom, 4'($urandom),
                int'($urandom_range(1, 4)));
    end
  endtask

  initial begin
    cmem_read = 1'b0; cmem_write = 1'b0; cmem_byte_enable = 4'h0;
    cmem_address = 32'h0; cmem_wdata = 32'h0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    last_rdata = 32'h0; last_wb_word0 = 32'h0;
    clear_model();
    test_reset();
    test_directed();
    test_read_write_both();
    test_spurious_resp();
    test_reset_mid_fetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/l1_cache.md
L1_CACHE -- requirements
Module: l1_cache

Interface
REQ-001 Parameter NUM_SETS, default 8: direct-mapped set count, power of two.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 cmem_read  input  1  CPU read request; held until cmem_resp.
REQ-005 cmem_write  input  1  CPU write request; held until cmem_resp.
REQ-006 cmem_byte_enable  input  4  byte lanes for write.
REQ-007 cmem_address  input  32  byte address; bits [1:0] ignored.
REQ-008 cmem_wdata  input  32  write data.
REQ-009 cmem_resp  output  1  one-cycle completion pulse.
REQ-010 cmem_rdata  output  32  read data, valid while cmem_resp=1.
REQ-011 pmem_read  output  1  line fetch request to memory.
REQ-012 pmem_write  output  1  line writeback request to memory.
REQ-013 pmem_address  output  32  line address, bits [4:0]=0.
REQ-014 pmem_wdata  output  256  writeback line.
REQ-015 pmem_rdata  input  256  fetched line, valid while pmem_resp=1.
REQ-016 pmem_resp  input  1  memory completion pulse.

Function
REQ-017 Address split SHALL be offset [4:0], index [4+log2(NUM_SETS):5], tag = remaining upper bits; line = 32 bytes = 8 words.
REQ-018 Per set the block SHALL hold valid, dirty, tag and a 256-bit line.
REQ-019 FSM states SHALL be IDLE, WRITEBACK, FETCH.
REQ-020 In IDLE, a request whose set is valid with matching tag (hit) SHALL assert cmem_resp combinationally in that same cycle.
REQ-021 Read hit: cmem_rdata SHALL be word address[4:2] of the line.
REQ-022 Write hit: on the responding clock edge, only lanes with cmem_byte_enable=1 SHALL be updated and dirty set to 1.
REQ-023 Miss with victim valid and dirty: IDLE->WRITEBACK; pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line, held until pmem_resp, then ->FETCH.
REQ-024 Miss otherwise: IDLE->FETCH; pmem_read=1, pmem_address={request tag, index, 5'b0}, held until pmem_resp.
REQ-025 On pmem_resp in FETCH: line<=pmem_rdata, tag<=request tag, valid<=1, dirty<=0, ->IDLE; the still-held request then hits in the next cycle (read miss latency = pmem cycles + 2).
REQ-026 pmem_read and pmem_write SHALL never both be 1; neither SHALL be 1 in IDLE.
REQ-027 cmem_resp SHALL be 0 outside IDLE and when no request is present; cmem_rdata SHALL be 0 when cmem_resp=0.
REQ-028 cmem_read and cmem_write both 1 SHALL be treated as write.
REQ-029 pmem_resp while neither pmem_read nor pmem_write is asserted SHALL be ignored.
REQ-030 Request fields SHALL be used live (not latched); the CPU holds them stable until cmem_resp.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, all valid and dirty bits 0, pmem_read=0, pmem_write=0, cmem_resp=0, independent of clk.
REQ-032 Reset mid-WRITEBACK or mid-FETCH SHALL abandon the transfer with no array update; line data and tags need not reset.

Structure
REQ-033 Shared package SHALL hold the FSM state enum, line width (256), offset width (5), and tag/index width functions of NUM_SETS.
REQ-034 Storage SHALL be one sub-module, cache_array: combinational read, per-set write with 32-byte enable; valid/dirty kept in l1_cache for async clear.

Verification
REQ-035 Cold read 0x0000_0040, pmem returns line with word0=0xDEADBEEF after 3 cycles -> one pmem_read at 0x40, then cmem_resp with rdata 0xDEADBEEF, no pmem_write.
REQ-036 Repeat read 0x0000_0044 -> cmem_resp same cycle, no pmem activity.
REQ-037 Write 0x0000_0040 data 0x11223344 be=4'b0011, then read -> rdata 0xDEAD3344.
REQ-038 Read 0x0000_0140 (same index, new tag) after REQ-037 -> pmem_write at 0x40 with word0 0xDEAD3344, then pmem_read at 0x140, then cmem_resp.
REQ-039 rst_n pulsed low during FETCH -> pmem_read drops asynchronously; subsequent read to same address misses.
REQ-040 Read and write asserted together on a hit -> treated as write, dirty set, one cmem_resp.
